// File: rtl/bert_pkg.sv
// Shared types and constants for the BERT run sequencer.
package bert_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED,
      S_SYNC,
      S_MEASURE,
      S_DONE
   } state_t;

   localparam logic [1:0] ST_NONE      = 2'b00;
   localparam logic [1:0] ST_PASS      = 2'b01;
   localparam logic [1:0] ST_SYNC_FAIL = 2'b10;
   localparam logic [1:0] ST_ABORT     = 2'b11;

   localparam int DEF_SYNC_LEN     = 16;
   localparam int DEF_SYNC_TIMEOUT = 1024;

endpackage

// File: rtl/bert_popcount.sv
// Combinational population count of a checker error word.
module bert_popcount #(
   parameter int WORD_W = 8,
   parameter int PC_W   = $clog2(WORD_W) + 1
) (
   input  logic [WORD_W-1:0] vec,
   output logic [PC_W-1:0]   count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < WORD_W; i++)
         count = count + PC_W'(vec[i]);
   end

endmodule

// File: rtl/bert_test_sequencer.sv
// Run-level controller: seeds generator/checker, waits for sync, then measures
// a window of words and accumulates a saturating bit-error total.
module bert_test_sequencer
   import bert_pkg::*;
#(
   parameter int WORD_W       = 8,
   parameter int CNT_W        = 32,
   parameter int SYNC_LEN     = DEF_SYNC_LEN,
   parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              sel,
   input  logic [2:0]        taps,
   input  logic [CNT_W-1:0]  window,
   input  logic              err_valid,
   input  logic [WORD_W-1:0] err_vec,
   output logic              gen_load,
   output logic              gen_en,
   output logic              gen_sel,
   output logic [2:0]        gen_taps,
   output logic              chk_clear,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  error_total
);

   localparam int PC_W  = $clog2(WORD_W) + 1;
   localparam int RUN_W = $clog2(SYNC_LEN + 1);
   localparam int TO_W  = $clog2(SYNC_TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_LEN - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(SYNC_TIMEOUT - 1);

   state_t             state;
   logic [CNT_W-1:0]   window_q;
   logic [RUN_W-1:0]   run_cnt;
   logic [TO_W-1:0]    to_cnt;
   logic [PC_W-1:0]    pop;
   logic [CNT_W:0]     err_sum;
   logic [CNT_W-1:0]   err_next;
   logic               clean_word;
   logic               fin;
   logic [1:0]         fin_st;
   logic               to_meas;
   logic               count_word;

   bert_popcount #(.WORD_W(WORD_W), .PC_W(PC_W)) u_pop (
      .vec   (err_vec),
      .count (pop)
   );

   // One extra carry bit detects overflow so the total clamps instead of wrapping.
   assign err_sum    = {1'b0, error_total} + (CNT_W+1)'(pop);
   assign err_next   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
   assign clean_word = err_valid && (err_vec == '0);

   always_comb begin
      fin        = 1'b0;
      fin_st     = ST_NONE;
      to_meas    = 1'b0;
      count_word = 1'b0;
      case (state)
         S_SEED: begin
            if (abort) begin
               fin    = 1'b1;
               fin_st = ST_ABORT;
            end
         end
         S_SYNC: begin
            if (abort) begin
               fin    = 1'b1;
               fin_st = ST_ABORT;
            end else if (clean_word && run_cnt == RUN_LAST) begin
               to_meas = 1'b1;
            end else if (to_cnt == TO_LAST) begin
               fin    = 1'b1;
               fin_st = ST_SYNC_FAIL;
            end
         end
         S_MEASURE: begin
            if (abort) begin
               fin    = 1'b1;
               fin_st = ST_ABORT;
            end else if (window_q == '0) begin
               fin    = 1'b1;
               fin_st = ST_PASS;
            end else if (err_valid) begin
               count_word = 1'b1;
               if (word_count == window_q - 1'b1) begin
                  fin    = 1'b1;
                  fin_st = ST_PASS;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         window_q    <= '0;
         run_cnt     <= '0;
         to_cnt      <= '0;
         gen_load    <= 1'b0;
         gen_en      <= 1'b0;
         gen_sel     <= 1'b0;
         gen_taps    <= '0;
         chk_clear   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         status      <= ST_NONE;
         word_count  <= '0;
         error_total <= '0;
      end else begin
         gen_load  <= 1'b0;
         chk_clear <= 1'b0;
         done      <= 1'b0;
         // The final accepted word is counted in the same cycle the run finishes.
         if (count_word) begin
            word_count  <= word_count + 1'b1;
            error_total <= err_next;
         end
         if (fin) begin
            state  <= S_DONE;
            status <= fin_st;
            done   <= 1'b1;
            busy   <= 1'b0;
            gen_en <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start && !abort) begin
                     state       <= S_SEED;
                     gen_sel     <= sel;
                     gen_taps    <= taps;
                     window_q    <= window;
                     run_cnt     <= '0;
                     to_cnt      <= '0;
                     word_count  <= '0;
                     error_total <= '0;
                     status      <= ST_NONE;
                     gen_load    <= 1'b1;
                     chk_clear   <= 1'b1;
                     busy        <= 1'b1;
                  end
               end
               S_SEED: begin
                  state  <= S_SYNC;
                  gen_en <= 1'b1;
               end
               S_SYNC: begin
                  if (to_meas) begin
                     state <= S_MEASURE;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                     if (clean_word)
                        run_cnt <= run_cnt + 1'b1;
                     else if (err_valid)
                        run_cnt <= '0;
                  end
               end
               S_MEASURE: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/bert_test_sequencer.md
# bert_test_sequencer

Run-level controller for the bit-error-ratio tester datapath. It configures the pattern generator and checker, waits for the checker to reach sync, and counts received words over a programmed measurement window. It accumulates per-word bit errors into a saturating total and reports a completion status. It sits between the host/register interface and the existing generator/checker pair, which it drives through load/enable/clear strobes.

## Interface
- WORD_W, 8, width of the checker error vector (bits per word)
- CNT_W, 32, width of the word and error counters
- SYNC_LEN, 16, consecutive error-free words required to declare sync
- SYNC_TIMEOUT, 1024, max cycles spent in SYNC before failing
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  one-cycle request; accepted only in IDLE or DONE
- abort  in  1  terminate the current run
- sel  in  1  1 = PRBS pattern mode, 0 = normal-input passthrough; latched at start
- taps  in  3  generator polynomial select; latched at start
- window  in  CNT_W  number of words to measure; latched at start
- err_valid  in  1  checker presents a compared word this cycle
- err_vec  in  WORD_W  per-bit mismatch mask for that word
- gen_load  out  1  one-cycle pulse: load seed and taps into generator
- gen_en  out  1  generator/checker running
- gen_sel  out  1  latched sel
- gen_taps  out  3  latched taps
- chk_clear  out  1  one-cycle pulse: clear checker internal state
- busy  out  1  high in SEED, SYNC, MEASURE
- done  out  1  one-cycle pulse on entry to DONE
- status  out  2  00 none, 01 pass, 10 sync_fail, 11 aborted
- word_count  out  CNT_W  words measured in the current/last run
- error_total  out  CNT_W  bit errors accumulated, saturating

## Operation
- States: IDLE, SEED, SYNC, MEASURE, DONE.
- IDLE/DONE + start (no abort): latch sel/taps/window, clear word_count, error_total, status, sync run and timeout counters; go to SEED.
- SEED (1 cycle): gen_load=1, chk_clear=1; go to SYNC.
- SYNC: gen_en=1. A clean word (err_valid, err_vec==0) increments the run counter; a dirty word resets it to 0. When the run reaches SYNC_LEN, go to MEASURE. The timeout counter increments every cycle; on reaching SYNC_TIMEOUT, go to DONE with status 10.
- MEASURE: gen_en=1. Each err_valid word increments word_count and adds popcount(err_vec) to error_total. error_total clamps at 2^CNT_W-1 and never wraps. When an accepted word makes word_count==window, go to DONE with status 01.
- window==0: SYNC still runs; MEASURE exits on its first cycle with counts 0 and status 01.
- abort in SEED/SYNC/MEASURE: go to DONE with status 11 and counters frozen. Abort has priority over a same-cycle word (word not counted) and over a same-cycle start. Abort in IDLE/DONE is ignored.
- DONE: gen_en=0. Results hold until the next accepted start.
- start while busy is ignored.

## Timing
- Reset values: state IDLE, every output 0 (status 00, counters 0, gen_sel/gen_taps 0).
- start at cycle t: SEED at t+1 (gen_load, chk_clear, busy high); SYNC at t+2.
- SYNC exit: the SYNC_LEN-th clean word at cycle s puts MEASURE at s+1. Words during the exit cycle s are not measured.
- Final word at cycle m: DONE at m+1, done high for cycle m+1 only; word_count/error_total are final at m+1.
- Counters update the cycle after the word; there is no pipeline beyond one register stage.
- Reset mid-run: returns to IDLE on the next edge; the run is lost and no done pulse is issued.

## Structure
- Shared package bert_pkg: state enum, status code constants (ST_NONE/PASS/SYNC_FAIL/ABORT), default SYNC_LEN/SYNC_TIMEOUT.
- Sub-module bert_popcount (WORD_W-in, $clog2(WORD_W)+1-out, combinational) feeding the saturating adder.
- The FSM, latches and counters live in bert_test_sequencer.

## Test plan
- Clean run: window=100, SYNC_LEN=16, err_vec=0 every cycle → done 118 cycles after start, status 01, word_count 100, error_total 0.
- Errors: window=10, err_vec=8'b0000_0101 on 3 measured words → error_total 6, word_count 10, status 01.
- Sync fail: err_vec=8'h01 on every 8th word, SYNC_TIMEOUT=64 → DONE at 64 cycles in SYNC, status 10, counts 0.
- Abort: abort asserted on the same cycle as the 5th measured word, with err_vec=8'hFF → status 11, word_count 4; a following start restarts from SEED with counters 0.
- Saturation: CNT_W=8, err_vec=8'hFF, window=40 → error_total 255, word_count 40.
- Reset mid-MEASURE and start during MEASURE → reset gives all outputs 0; start is ignored with no state change.
